// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding an 8N1 UART transmitter with CTS flow control and frame counter
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       CPU_RESETN,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       cts_n,
    output logic       UART_RXD_OUT,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BAUD_LAST  = CW'(DIV - 1);
    localparam logic [AW:0]   DEPTH_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic          cts_meta, cts_sync;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop;

    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_q;
    logic          line_q, line_d;
    logic          bit_done, frame_done;

    // Two-flop synchroniser; reset to "not clear" so nothing starts before the host is seen.
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            cts_meta <= 1'b1;
            cts_sync <= 1'b1;
        end else begin
            cts_meta <= cts_n;
            cts_sync <= cts_meta;
        end
    end

    assign full     = (count == DEPTH_FULL);
    assign empty    = (count == '0);
    assign tx_ready = !full;
    assign push     = tx_valid && !full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bit_done = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        line_d     = 1'b1;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !cts_sync) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                line_d = 1'b0;
                if (bit_done) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                line_d = shift_q[bit_idx];
                if (bit_done && (bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                line_d = ^shift_q;
                if (bit_done) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    state_d    = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The line is registered from the current state, so it trails the state by one cycle.
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q   <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_q   <= '0;
            line_q    <= 1'b1;
            frame_cnt <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            if (pop) begin
                shift_q  <= mem[rd_ptr];
                baud_cnt <= '0;
                bit_idx  <= '0;
            end else if (state_q != IDLE) begin
                baud_cnt <= bit_done ? '0 : baud_cnt + 1'b1;
                if (bit_done && (state_q == DATA)) begin
                    bit_idx <= bit_idx + 1'b1;
                end
            end
            if (frame_done) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign UART_RXD_OUT = line_q;
    assign busy         = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized and directed bench for uart_tx_fifo against a frame-level queue model
module tb_uart_tx_fifo;

    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 125000;
    localparam int DEPTH  = 4;
    localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       cts_n = 1'b0;
    logic       line;
    logic       busy;
    logic [7:0] frame_cnt;

    int vectors = 0;
    int miscompares = 0;

    uart_tx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .CPU_RESETN(rst_n),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .cts_n(cts_n),
        .UART_RXD_OUT(line),
        .busy(busy),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line level during frame bit b (0 = start, 1..8 = data LSB first, then parity/stop).
    function automatic logic frame_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    logic [7:0] mq[$];
    logic       m_active = 1'b0;
    int         m_pos = 0;
    logic [7:0] m_cur = 8'h00;
    logic       m_line = 1'b1;
    logic [7:0] m_cnt = 8'h00;
    logic       m_s1 = 1'b1;
    logic       m_s2 = 1'b1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mq.delete();
                m_active = 1'b0;
                m_pos    = 0;
                m_line   = 1'b1;
                m_cnt    = 8'h00;
                m_s1     = 1'b1;
                m_s2     = 1'b1;
            end else begin
                logic act_pre;
                int   size_pre;
                act_pre  = m_active;
                size_pre = mq.size();
                m_line   = act_pre ? frame_bit(m_cur, m_pos / DIV) : 1'b1;
                if (act_pre) begin
                    if (m_pos == FL - 1) begin
                        m_active = 1'b0;
                        m_cnt    = m_cnt + 8'd1;
                    end else begin
                        m_pos++;
                    end
                end else if (size_pre > 0 && !m_s2) begin
                    m_cur    = mq.pop_front();
                    m_active = 1'b1;
                    m_pos    = 0;
                end
                if (tx_valid && size_pre < DEPTH) mq.push_back(tx_data);
                m_s2 = m_s1;
                m_s1 = cts_n;
            end
            check("model_line", line, m_line);
            check("model_ready", tx_ready, mq.size() < DEPTH);
            check("model_busy", busy, m_active || mq.size() > 0);
            check("model_frame_cnt", frame_cnt, m_cnt);
        end
    end

    task automatic push(input logic [7:0] d);
        int budget = 4 * FL;
        while (!tx_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("push_timeout", 0, 1);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        while (busy && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic wait_line_low(input int budget);
        while (line && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("start_timeout", line, 0);
    endtask

    task automatic check_frame(input logic [7:0] d, input logic [10:0] exp);
        push(d);
        @(negedge clk);
        check("lat_n1", line, 1);
        @(negedge clk);
        check("lat_n2", line, 0);
        for (int k = 0; k < NB; k++) begin
            repeat ((k == 0) ? DIV / 2 : DIV) @(negedge clk);
            check("frame_bit", line, exp[k]);
        end
        repeat (DIV / 2 - 2) @(negedge clk);
        check("busy_last", busy, 1);
        @(negedge clk);
        check("busy_clear", busy, 0);
    endtask

    initial begin
        int budget;
        repeat (3) @(negedge clk);
        check("rst_line", line, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_cnt", frame_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef UART_TX_PARITY_EN
        check_frame(8'h55, 11'b1_0_01010101_0);
`else
        check_frame(8'h55, 11'b0_1_01010101_0);
`endif
        check("t1_cnt", frame_cnt, 1);

        cts_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 1; i <= 4; i++) push(8'(i));
        check("t2_full", tx_ready, 0);
        repeat (20) @(negedge clk);
        check("t2_held", line, 1);
        cts_n = 1'b0;
        wait_idle(8 * FL);
        check("t2_cnt", frame_cnt, 5);

        push(8'hA5);
        push(8'h3C);
        wait_line_low(4 * FL);
        repeat (4 * DIV + 2) @(negedge clk);
        cts_n = 1'b1;
        budget = 2 * FL;
        while (frame_cnt != 8'd6 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("t3_cnt", frame_cnt, 6);
        repeat (10) @(negedge clk);
        check("t3_held", line, 1);
        check("t3_busy", busy, 1);
        cts_n = 1'b0;
        @(negedge clk);
        check("t3_sync1", line, 1);
        @(negedge clk);
        check("t3_sync2", line, 1);
        @(negedge clk);
        check("t3_sync3", line, 1);
        @(negedge clk);
        check("t3_start", line, 0);
        wait_idle(4 * FL);

        push(8'hFF);
        push(8'h11);
        push(8'h22);
        wait_line_low(4 * FL);
        repeat (DIV + 3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t4_line", line, 1);
        check("t4_ready", tx_ready, 1);
        check("t4_busy", busy, 0);
        check("t4_cnt", frame_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * FL) @(negedge clk);
        check("t4_quiet_cnt", frame_cnt, 0);
        check("t4_quiet_busy", busy, 0);

        for (int i = 0; i < 256; i++) push(8'h00);
        wait_idle(8 * FL);
        check("t5_wrap", frame_cnt, 0);

`ifdef UART_TX_PARITY_EN
        check_frame(8'h07, 11'b1_1_00000111_0);
        check_frame(8'h03, 11'b1_0_00000011_0);
`endif

        for (int i = 0; i < 2000; i++) begin
            tx_valid = 1'($urandom_range(0, 1));
            tx_data  = 8'($urandom);
            if ($urandom_range(0, 99) < 3) cts_n = ~cts_n;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        cts_n    = 1'b0;
        wait_idle((DEPTH + 2) * FL);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
